// File: rtl/coherence_agent.sv
// Direct-mapped, one-word-per-line MSI cache agent that sits between a core and a snooping bus.
// Snoops are taken only from IDLE; a core request that loses to a snoop repeats its lookup from IDLE.
module coherence_agent #(
    parameter int LINES = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        creq_ren,
    input  logic        creq_wen,
    input  logic [31:0] creq_addr,
    input  logic [31:0] creq_wdata,
    output logic [31:0] creq_rdata,
    output logic        creq_done,
    output logic        dREN,
    output logic        dWEN,
    output logic [31:0] daddr,
    output logic [31:0] dstore,
    input  logic [31:0] dload,
    input  logic        dwait,
    output logic        ccwrite,
    output logic        cctrans,
    input  logic        ccwait,
    input  logic        ccinv,
    input  logic [31:0] ccsnoopaddr
);
    localparam int IW = $clog2(LINES);
    localparam int TW = 30 - IW;

    typedef enum logic [2:0] {IDLE, WB, FETCH, SNP, SNPWB, DONE} state_t;
    typedef enum logic [1:0] {MSI_I, MSI_S, MSI_M} msi_t;

    state_t state, next;
    msi_t   msi  [LINES];
    logic [TW-1:0] tags [LINES];
    logic [31:0]   data [LINES];

    logic [IW-1:0] cidx, sidx;
    logic [TW-1:0] ctag, stag;
    logic          c_hit, s_hit;
    msi_t          c_st, s_st;

    assign cidx  = creq_addr[2+IW-1:2];
    assign ctag  = creq_addr[31:2+IW];
    assign sidx  = ccsnoopaddr[2+IW-1:2];
    assign stag  = ccsnoopaddr[31:2+IW];
    assign c_st  = msi[cidx];
    assign s_st  = msi[sidx];
    assign c_hit = (c_st != MSI_I) && (tags[cidx] == ctag);
    assign s_hit = (s_st != MSI_I) && (tags[sidx] == stag);

    logic          bus_ren, bus_wen, bus_ccw, done;
    logic [31:0]   bus_addr, bus_data, rdata;
    logic          st_we, fill, dw, trans;
    logic [IW-1:0] st_idx;
    msi_t          st_new;
    logic [31:0]   fill_val;
    logic          trans_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next;
    end

    always_comb begin
        next     = state;
        bus_ren  = 1'b0;
        bus_wen  = 1'b0;
        bus_ccw  = 1'b0;
        bus_addr = '0;
        bus_data = '0;
        done     = 1'b0;
        rdata    = '0;
        st_we    = 1'b0;
        st_idx   = cidx;
        st_new   = MSI_I;
        fill     = 1'b0;
        fill_val = dload;
        dw       = 1'b0;
        case (state)
            IDLE: begin
                if (ccwait) next = SNP;
                else if (creq_ren || creq_wen) begin
                    if (c_hit && (creq_ren || c_st == MSI_M)) begin
                        next = DONE;
                        dw   = creq_wen;
                    end else if (!c_hit && c_st == MSI_M) next = WB;
                    else next = FETCH;
                end
            end
            WB: begin
                bus_wen  = 1'b1;
                bus_addr = {tags[cidx], cidx, 2'b00};
                bus_data = data[cidx];
                if (!dwait) next = FETCH;
            end
            FETCH: begin
                bus_ren  = 1'b1;
                bus_addr = creq_addr;
                bus_ccw  = creq_wen;
                if (!dwait) begin
                    fill     = 1'b1;
                    fill_val = creq_wen ? creq_wdata : dload;
                    st_we    = 1'b1;
                    st_new   = creq_wen ? MSI_M : MSI_S;
                    next     = DONE;
                end
            end
            SNP: begin
                next = IDLE;
                if (s_hit && s_st == MSI_M) next = SNPWB;
                else if (s_hit && ccinv) begin
                    st_we  = 1'b1;
                    st_idx = sidx;
                    st_new = MSI_I;
                end
            end
            SNPWB: begin
                bus_wen  = 1'b1;
                bus_addr = ccsnoopaddr;
                bus_data = data[sidx];
                if (!dwait) begin
                    st_we  = 1'b1;
                    st_idx = sidx;
                    st_new = ccinv ? MSI_I : MSI_S;
                    next   = IDLE;
                end
            end
            DONE: begin
                done  = 1'b1;
                rdata = data[cidx];
                next  = IDLE;
            end
            default: next = IDLE;
        endcase
    end

    // A fill always installs a new tag or state, so it always counts as a transition.
    assign trans = st_we && ((msi[st_idx] != st_new) || fill);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < LINES; i++) msi[i] <= MSI_I;
            trans_q <= 1'b0;
        end else begin
            if (st_we) msi[st_idx] <= st_new;
            trans_q <= trans;
        end
    end

    always_ff @(posedge CLK) begin
        if (fill) begin
            tags[cidx] <= ctag;
            data[cidx] <= fill_val;
        end else if (dw) begin
            data[cidx] <= creq_wdata;
        end
    end

    // Outputs are gated so an asserted reset drops bus requests within the same cycle.
    assign dREN       = bus_ren & ~RST;
    assign dWEN       = bus_wen & ~RST;
    assign ccwrite    = bus_ccw & ~RST;
    assign daddr      = RST ? '0 : bus_addr;
    assign dstore     = RST ? '0 : bus_data;
    assign creq_done  = done & ~RST;
    assign creq_rdata = RST ? '0 : rdata;
    assign cctrans    = trans_q & ~RST;
endmodule

// File: tb/tb_coherence_agent.sv
// Directed checks of the coherence agent: fills, upgrades, writebacks, snoops and reset.
module tb_coherence_agent;
    logic        CLK = 1'b0, RST = 1'b1;
    logic        creq_ren = 0, creq_wen = 0;
    logic [31:0] creq_addr = 0, creq_wdata = 0, creq_rdata;
    logic        creq_done, dREN, dWEN, ccwrite, cctrans;
    logic [31:0] daddr, dstore, dload = 0, ccsnoopaddr = 0;
    logic        dwait = 1, ccwait = 0, ccinv = 0;

    int total = 0, bad = 0;
    int n_ren, n_wen, n_trans, n_done, done_at;
    logic [31:0] rdata_s, wb_addr, wb_data, fetch_addr;
    logic ccw_s;

    coherence_agent #(.LINES(8)) dut (
        .CLK(CLK), .RST(RST),
        .creq_ren(creq_ren), .creq_wen(creq_wen), .creq_addr(creq_addr),
        .creq_wdata(creq_wdata), .creq_rdata(creq_rdata), .creq_done(creq_done),
        .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
        .dload(dload), .dwait(dwait), .ccwrite(ccwrite), .cctrans(cctrans),
        .ccwait(ccwait), .ccinv(ccinv), .ccsnoopaddr(ccsnoopaddr)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Runs n cycles from the current IDLE cycle, acting as bus (waits stall cycles
    // per transfer) and core (drops its request on done); ccwait is a one-cycle pulse.
    task automatic run(input int waits, input int n);
        int w = waits;
        n_ren = 0; n_wen = 0; n_trans = 0; n_done = 0; done_at = -1;
        rdata_s = 0; wb_addr = 0; wb_data = 0; fetch_addr = 0; ccw_s = 0;
        for (int i = 0; i < n; i++) begin
            logic saw_done;
            saw_done = creq_done;
            if (dREN) begin n_ren++; fetch_addr = daddr; ccw_s = ccw_s | ccwrite; end
            if (dWEN) begin n_wen++; wb_addr = daddr; wb_data = dstore; end
            if (cctrans) n_trans++;
            if (creq_done) begin
                if (n_done == 0) begin done_at = i; rdata_s = creq_rdata; end
                n_done++;
            end
            if (dREN || dWEN) begin
                if (w > 0) begin dwait = 1; w--; end
                else begin dwait = 0; w = waits; end
            end else dwait = 1;
            @(posedge CLK); #1;
            if (i == 0) ccwait = 0;
            if (saw_done) begin creq_ren = 0; creq_wen = 0; end
        end
        dwait = 1;
    endtask

    task automatic load(input logic [31:0] a, input logic [31:0] bus_val, input int waits);
        creq_addr = a; dload = bus_val; creq_ren = 1;
        run(waits, 12);
    endtask

    task automatic store(input logic [31:0] a, input logic [31:0] v, input int waits);
        creq_addr = a; creq_wdata = v; dload = 32'hDEAD_0000; creq_wen = 1;
        run(waits, 12);
    endtask

    initial begin
        #1;
        chk("rst_dren", dREN, 0);
        chk("rst_dwen", dWEN, 0);
        chk("rst_done", creq_done, 0);
        chk("rst_trans", cctrans, 0);
        chk("rst_daddr", daddr, 0);
        @(posedge CLK); @(posedge CLK); #1;
        RST = 0;

        // cold load with 3 stall cycles
        load(32'h100, 32'hCAFE, 3);
        chk("ld1_ren_cycles", n_ren, 4);
        chk("ld1_wen", n_wen, 0);
        chk("ld1_rdata", rdata_s, 32'hCAFE);
        chk("ld1_done_at", done_at, 5);
        chk("ld1_done_cnt", n_done, 1);
        chk("ld1_trans", n_trans, 1);
        chk("ld1_faddr", fetch_addr, 32'h100);

        // store to shared line upgrades with read-exclusive
        store(32'h100, 32'h1234, 0);
        chk("up_ccwrite", ccw_s, 1);
        chk("up_ren", n_ren, 1);
        chk("up_done_at", done_at, 2);
        chk("up_trans", n_trans, 1);

        load(32'h100, 32'hFFFF, 0);
        chk("hit_done_at", done_at, 1);
        chk("hit_ren", n_ren, 0);
        chk("hit_wen", n_wen, 0);
        chk("hit_rdata", rdata_s, 32'h1234);
        chk("hit_trans", n_trans, 0);

        // conflict miss evicts the modified victim
        load(32'h120, 32'hBEEF, 1);
        chk("wb_wen_cycles", n_wen, 2);
        chk("wb_addr", wb_addr, 32'h100);
        chk("wb_data", wb_data, 32'h1234);
        chk("wb_faddr", fetch_addr, 32'h120);
        chk("wb_ren_cycles", n_ren, 2);
        chk("wb_ccwrite", ccw_s, 0);
        chk("wb_rdata", rdata_s, 32'hBEEF);
        chk("wb_done_at", done_at, 5);

        // store miss over a shared victim: no writeback
        store(32'h100, 32'h1234, 0);
        chk("sm_wen", n_wen, 0);
        chk("sm_ccwrite", ccw_s, 1);
        chk("sm_done_at", done_at, 2);
        chk("sm_trans", n_trans, 1);

        // invalidating snoop on a modified line
        ccsnoopaddr = 32'h100; ccinv = 1; ccwait = 1;
        run(0, 8);
        ccinv = 0;
        chk("snp_wen", n_wen, 1);
        chk("snp_addr", wb_addr, 32'h100);
        chk("snp_data", wb_data, 32'h1234);
        chk("snp_trans", n_trans, 1);
        chk("snp_done", n_done, 0);

        load(32'h100, 32'h77, 0);
        chk("inv_wen", n_wen, 0);
        chk("inv_ren", n_ren, 1);
        chk("inv_rdata", rdata_s, 32'h77);

        // snoop and load arrive together: snoop first, then load hits
        store(32'h100, 32'hAAAA, 0);
        ccsnoopaddr = 32'h100; ccinv = 0; ccwait = 1;
        creq_addr = 32'h100; creq_ren = 1;
        run(0, 10);
        chk("race_wen", n_wen, 1);
        chk("race_wb_data", wb_data, 32'hAAAA);
        chk("race_ren", n_ren, 0);
        chk("race_done_at", done_at, 4);
        chk("race_rdata", rdata_s, 32'hAAAA);
        chk("race_trans", n_trans, 1);

        // data-only update on a modified line
        store(32'h100, 32'hBBBB, 0);
        store(32'h100, 32'hCCCC, 0);
        chk("wh_done_at", done_at, 1);
        chk("wh_ren", n_ren, 0);
        chk("wh_trans", n_trans, 0);
        load(32'h100, 32'h0, 0);
        chk("wh_rdata", rdata_s, 32'hCCCC);

        // reset in the middle of a writeback
        creq_addr = 32'h120; creq_ren = 1; dwait = 1;
        @(posedge CLK); #1;
        chk("mid_wb_dwen", dWEN, 1);
        RST = 1; #1;
        chk("mid_rst_dwen", dWEN, 0);
        chk("mid_rst_daddr", daddr, 0);
        creq_ren = 0;
        @(posedge CLK); #1;
        RST = 0;
        load(32'h100, 32'h55, 0);
        chk("post_rst_wen", n_wen, 0);
        chk("post_rst_ren", n_ren, 1);
        chk("post_rst_rdata", rdata_s, 32'h55);
        chk("post_rst_trans", n_trans, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/coherence_agent.md
COHERENCE_AGENT -- requirements
Module: coherence_agent

Interface
REQ-001 SHALL have parameter: LINES, 8, number of direct-mapped one-word lines (power of two, 2..64).
REQ-002 SHALL have ports: CLK  in  1  rising-edge clock.
REQ-003 SHALL have ports: RST  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports: creq_ren  in  1  core load request, held until creq_done.
REQ-005 SHALL have ports: creq_wen  in  1  core store request, held until creq_done; never set together with creq_ren.
REQ-006 SHALL have ports: creq_addr  in  32  core word address; bits[1:0] ignored.
REQ-007 SHALL have ports: creq_wdata  in  32  core store data.
REQ-008 SHALL have ports: creq_rdata  out  32  load data, valid while creq_done=1.
REQ-009 SHALL have ports: creq_done  out  1  one-cycle completion pulse.
REQ-010 SHALL have ports: dREN, dWEN  out  1 each  bus read and write requests.
REQ-011 SHALL have ports: daddr, dstore  out  32 each  bus address and bus write data.
REQ-012 SHALL have ports: dload  in  32  bus read data; dwait  in  1  bus stall, data valid when 0.
REQ-013 SHALL have ports: ccwrite  out  1  bus read is for ownership (read-exclusive).
REQ-014 SHALL have ports: cctrans  out  1  one-cycle pulse on any line state change.
REQ-015 SHALL have ports: ccwait  in  1  snoop pending; ccinv  in  1  snoop invalidates; ccsnoopaddr  in  32  snooped address.

Function
REQ-016 SHALL use index = addr[2+log2(LINES)-1:2] and tag = remaining upper bits; each line holds tag, 32-bit data and MSI state (I, S, M).
REQ-017 SHALL run the FSM states IDLE, WB, FETCH, SNP, SNPWB, DONE.
REQ-018 SHALL sample ccwait only in IDLE; ccwait=1 in IDLE SHALL win over any core request and go to SNP.
REQ-019 SNP: on tag match with M -> SNPWB; on match with S -> set I if ccinv, else stay S; then IDLE; on no match or I -> IDLE, no change.
REQ-020 SNPWB: drive dWEN=1, daddr=ccsnoopaddr, dstore=line data until dwait=0; then set S, or I if ccinv=1; then IDLE.
REQ-021 In IDLE, read hit (S/M) or write hit (M) SHALL go to DONE; a write hit also updates the data.
REQ-022 Write hit on S SHALL go to FETCH with ccwrite=1 (upgrade); the line stays S until the fill completes.
REQ-023 Miss with victim in M SHALL go to WB: dWEN=1, daddr={victim tag,index,2'b00}, dstore=victim data until dwait=0, then FETCH.
REQ-024 Miss with victim in S or I SHALL go directly to FETCH; no bus write.
REQ-025 FETCH: drive dREN=1, daddr=creq_addr, ccwrite=creq_wen until dwait=0; then latch dload, write the tag, and go to DONE.
REQ-026 FETCH line state: on a read, S; on a write, M with data=creq_wdata, overwriting dload.
REQ-027 DONE: creq_done=1 for exactly one cycle, creq_rdata=line data; then IDLE.
REQ-028 A new core request SHALL NOT be accepted in the cycle DONE is exited; the core must deassert its request on seeing creq_done.
REQ-029 dREN, dWEN and ccwrite SHALL be 0 outside WB, FETCH and SNPWB.
REQ-030 cctrans SHALL pulse in the cycle after each MSI change, including S->M, M->S, S->I, M->I and I->S/M; it SHALL NOT pulse for a data-only update.
REQ-031 Snoop-to-same-index during a pending core miss SHALL be served first; the core miss restarts its lookup afterwards.

Reset
REQ-032 RST=1 SHALL force IDLE and set all lines to I (tags and data don't-care).
REQ-033 During reset, all outputs SHALL be 0; a reset mid-transaction SHALL drop bus requests immediately.

Verification
REQ-034 Reset, then load 0x100 with dwait=1 for 3 cycles and dload=0xCAFE -> dREN high for 4 cycles; creq_done with rdata 0xCAFE; line goes S; cctrans pulses once.
REQ-035 Store 0x100 (line S), data 0x1234 -> FETCH with ccwrite=1; line goes M; a following load of 0x100 completes in 2 cycles, with no bus activity, returning 0x1234.
REQ-036 Line M at 0x100, then load 0x120 mapping to the same index (LINES=8) -> WB writes 0x1234 to 0x100; then FETCH 0x120.
REQ-037 Line M at 0x100, snoop ccsnoopaddr=0x100 with ccinv=1 -> dWEN with dstore=0x1234; line goes I; cctrans pulses.
REQ-038 ccwait and creq_ren rising in the same cycle in IDLE -> snoop is handled first, then the load proceeds.
REQ-039 RST asserted during WB with dwait=1 -> dWEN is 0 the same cycle; after release all lines are I.
